image_arbiter: RTL and testbench



---
 rtl/image_arbiter.sv | 153 +++++++++++++++
 tb/tb_image_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_arbiter.sv
// Frame-granular round-robin arbiter: merges Inputs START/STOP-bracketed image streams onto one output.
// Optional stall timeout: define IMAGE_ARBITER_TIMEOUT_EN.
module image_arbiter #(
  parameter int Inputs        = 2,
  parameter int Data_w        = 8,
  parameter int Timeout_w     = 16,
  parameter int TimeoutCycles = 1000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [Inputs-1:0]        in_valid,
  output logic [Inputs-1:0]        in_ready,
  input  logic [Inputs-1:0]        in_start,
  input  logic [Inputs-1:0]        in_stop,
  input  logic [Inputs*Data_w-1:0] in_data,
  input  logic [Inputs-1:0]        in_error,
  output logic [Inputs-1:0]        in_request,
  output logic [Inputs-1:0]        in_cancel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_start,
  output logic                     out_stop,
  output logic [Data_w-1:0]        out_data,
  output logic                     out_error,
  input  logic                     out_request,
  input  logic                     out_cancel,
  output logic [Inputs-1:0]        grant,
  output logic                     busy
);
  // Handshake: a word moves when valid & ready are both high on a rising clock edge;
  // valid never depends on ready, ready may depend on valid.

  localparam int PtrW = $clog2(Inputs);

  if (Inputs < 2 || Inputs > 8 || Timeout_w < 1 || TimeoutCycles < 1) begin : g_bad_params
    $error("image_arbiter: parameter out of range");
  end

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            state_q;
  logic [Inputs-1:0] grant_q;
  logic [Inputs-1:0] in_cancel_q;
  logic [Inputs-1:0] in_request_q;
  logic [PtrW-1:0]   ptr_q;
  logic [PtrW-1:0]   gidx_q;
  logic              busy_q;

  logic              found;
  logic [PtrW-1:0]   pick;
  logic [PtrW-1:0]   idx;
  int                sum;
  logic [PtrW-1:0]   ptr_nxt;
  logic              xfer_stop;
  logic              timeout;

  // Rotating priority scan over START-valid ports, beginning at ptr_q.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    sum   = 0;
    for (int i = 0; i < Inputs; i++) begin
      sum = int'(ptr_q) + i;
      if (sum >= Inputs) sum = sum - Inputs;
      idx = PtrW'(sum);
      if (!found && in_valid[idx] && in_start[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign ptr_nxt   = (gidx_q == PtrW'(Inputs - 1)) ? '0 : gidx_q + 1'b1;
  assign xfer_stop = out_valid && out_ready && out_stop;

`ifdef IMAGE_ARBITER_TIMEOUT_EN
  logic [Timeout_w-1:0] stall_q;

  assign timeout = (state_q == GRANT) && (stall_q == Timeout_w'(TimeoutCycles));

  // Held at zero outside GRANT, so every new grant starts counting from zero.
  always_ff @(posedge clock) begin
    if (reset || state_q != GRANT) stall_q <= '0;
    else if (in_valid[gidx_q])     stall_q <= '0;
    else if (stall_q != '1)        stall_q <= stall_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    in_ready  = '0;
    out_valid = 1'b0;
    out_start = 1'b0;
    out_stop  = 1'b0;
    out_error = 1'b0;
    out_data  = '0;
    if (state_q == GRANT) begin
      out_valid = in_valid[gidx_q];
      out_start = in_start[gidx_q];
      out_stop  = in_stop[gidx_q];
      out_error = in_error[gidx_q] | timeout;
      out_data  = in_data[gidx_q*Data_w +: Data_w];
      in_ready  = grant_q & {Inputs{out_ready}};
    end else begin
      // Words outside a frame bracket are drained so they cannot block a source.
      in_ready = in_valid & ~in_start;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      ptr_q        <= '0;
      busy_q       <= 1'b0;
      in_cancel_q  <= '0;
      in_request_q <= '0;
    end else begin
      in_request_q <= {Inputs{out_request}};
      in_cancel_q  <= '0;
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q <= GRANT;
            grant_q <= Inputs'(1) << pick;
            gidx_q  <= pick;
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
          if (out_cancel || timeout) in_cancel_q[gidx_q] <= 1'b1;
          if (out_cancel || timeout || xfer_stop) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_nxt;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // busy doubles as the visible FSM state (1 = GRANT).
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign in_cancel  = in_cancel_q;
  assign in_request = in_request_q;

endmodule

// File: tb/tb_image_arbiter.sv
// Self-checking bench for image_arbiter: queue-based sources, frame-level round-robin model, scoreboard.
// Timeout checks are compiled in when IMAGE_ARBITER_TIMEOUT_EN is defined.
module tb_image_arbiter;
  localparam int N  = 2;
  localparam int W  = 8;
  localparam int WW = W + 3;  // {start, stop, error, data}

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   in_valid, in_ready, in_start, in_stop, in_error, in_request, in_cancel, grant;
  logic [N*W-1:0] in_data;
  logic           out_valid, out_ready, out_start, out_stop, out_error;
  logic           out_request, out_cancel, busy;
  logic [W-1:0]   out_data;

  always #5 clock = ~clock;

  image_arbiter #(.Inputs(N), .Data_w(W), .Timeout_w(16), .TimeoutCycles(10)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_start(in_start), .in_stop(in_stop),
    .in_data(in_data), .in_error(in_error), .in_request(in_request), .in_cancel(in_cancel),
    .out_valid(out_valid), .out_ready(out_ready), .out_start(out_start), .out_stop(out_stop),
    .out_data(out_data), .out_error(out_error), .out_request(out_request),
    .out_cancel(out_cancel), .grant(grant), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  logic [WW-1:0] src0_q[$], src1_q[$];
  logic [WW-1:0] exp_q[$];
  logic [N-1:0]  exp_grant_q[$];
  int            len0_q[$], len1_q[$];
  logic [N-1:0]  stall_mask = '0;
  bit            gaps = 0, rdy_rand = 0;

  logic [N-1:0]  obs_cancel, obs_request, obs_grant, obs_ready, prev_grant;
  logic          obs_busy, obs_error;
  bit            prev_stop_xfer;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    in_valid = '0; in_start = '0; in_stop = '0; in_error = '0; in_data = '0;
    out_ready = 1'b0; out_cancel = 1'b0;
    src0_q.delete(); src1_q.delete(); exp_q.delete(); exp_grant_q.delete();
    len0_q.delete(); len1_q.delete();
    stall_mask = '0; gaps = 0; rdy_rand = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    prev_grant = '0;
    prev_stop_xfer = 0;
  endtask

  // One clock cycle: drive sources, check outputs at negedge+1, pop accepted words at posedge.
  task automatic step(input logic rdy, input logic cancel);
    logic [WW-1:0] h, got, exp;
    logic [N-1:0]  hs;
    bit            have;
    @(negedge clock);
    // A cancelled source discards the rest of its current frame.
    if (in_cancel[0]) while (src0_q.size() > 0 && !src0_q[0][WW-1]) void'(src0_q.pop_front());
    if (in_cancel[1]) while (src1_q.size() > 0 && !src1_q[0][WW-1]) void'(src1_q.pop_front());
    for (int p = 0; p < N; p++) begin
      have = (p == 0) ? (src0_q.size() > 0) : (src1_q.size() > 0);
      h = '0;
      if (have) h = (p == 0) ? src0_q[0] : src1_q[0];
      in_valid[p] = have && !(stall_mask[p] && !h[WW-1]) &&
                    !(gaps && !h[WW-1] && $urandom_range(0, 3) == 0);
      in_start[p] = h[WW-1];
      in_stop[p]  = h[WW-2];
      in_error[p] = h[WW-3];
      in_data[p*W +: W] = h[W-1:0];
    end
    out_ready  = rdy_rand ? 1'($urandom_range(0, 1)) : rdy;
    out_cancel = cancel;
    #1;
    checks++;
    if ((grant & (grant - 2'd1)) !== '0) begin
      failures++; $display("FAIL grant_onehot: grant=%b", grant);
    end
    checks++;
    if (busy !== (grant != '0)) begin
      failures++; $display("FAIL busy_vs_grant: busy=%b grant=%b", busy, grant);
    end
    checks++;
    if (busy) begin
      if (in_ready !== (grant & {N{out_ready}})) begin
        failures++; $display("FAIL ready_mirror: in_ready=%b expected=%b", in_ready, grant & {N{out_ready}});
      end
    end else if ({in_ready, out_valid} !== {in_valid & ~in_start, 1'b0}) begin
      failures++;
      $display("FAIL idle_outputs: in_ready=%b out_valid=%b expected in_ready=%b out_valid=0",
               in_ready, out_valid, in_valid & ~in_start);
    end
    if (prev_stop_xfer) begin
      checks++;
      if (busy !== 1'b0 || grant !== '0) begin
        failures++; $display("FAIL idle_gap: busy=%b grant=%b expected 0/00", busy, grant);
      end
    end
    if (grant != '0 && prev_grant == '0) begin
      checks++;
      if (exp_grant_q.size() == 0) begin
        failures++; $display("FAIL grant_order: unexpected grant=%b", grant);
      end else begin
        exp = WW'(exp_grant_q.pop_front());
        if (grant !== exp[N-1:0]) begin
          failures++; $display("FAIL grant_order: grant=%b expected=%b", grant, exp[N-1:0]);
        end
      end
    end
    if (out_valid && out_ready) begin
      got = {out_start, out_stop, out_error, out_data};
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL out_word: unexpected word %h", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          failures++; $display("FAIL out_word: got=%h expected=%h", got, exp);
        end
      end
    end
    obs_cancel = in_cancel; obs_request = in_request; obs_grant = grant;
    obs_ready = in_ready; obs_busy = busy; obs_error = out_error;
    hs = in_valid & in_ready;
    prev_stop_xfer = out_valid && out_ready && out_stop;
    prev_grant = grant;
    @(posedge clock);
    if (hs[0]) void'(src0_q.pop_front());
    if (hs[1]) void'(src1_q.pop_front());
  endtask

  task automatic add_frame(input int p, input int len, input bit push_exp);
    logic [WW-1:0] w;
    for (int k = 0; k < len; k++) begin
      w = {k == 0, k == len - 1, 1'($urandom_range(0, 1)), W'($urandom_range(0, 255))};
      if (p == 0) src0_q.push_back(w); else src1_q.push_back(w);
      if (push_exp) exp_q.push_back(w);
    end
    if (p == 0) len0_q.push_back(len); else len1_q.push_back(len);
  endtask

  // Reference: whole frames leave in round-robin order, pointer moving past each finished owner.
  task automatic model_rr();
    logic [WW-1:0] c0[$], c1[$];
    int l0[$], l1[$];
    int ptr = 0, p, len;
    c0 = src0_q; c1 = src1_q; l0 = len0_q; l1 = len1_q;
    while (l0.size() + l1.size() > 0) begin
      p = ptr;
      if ((p == 0 && l0.size() == 0) || (p == 1 && l1.size() == 0)) p = 1 - p;
      len = (p == 0) ? l0.pop_front() : l1.pop_front();
      for (int k = 0; k < len; k++) exp_q.push_back((p == 0) ? c0.pop_front() : c1.pop_front());
      exp_grant_q.push_back(N'(1 << p));
      ptr = (p + 1) % N;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((src0_q.size() > 0 || src1_q.size() > 0 || exp_q.size() > 0 || obs_busy) && n < budget) begin
      step(1'b1, 1'b0);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++; $display("FAIL %s_drain: %0d cycles used, budget %0d", name, n, budget);
    end
    checks++;
    if (exp_q.size() != 0 || exp_grant_q.size() != 0) begin
      failures++;
      $display("FAIL %s_leftover: words=%0d grants=%0d expected 0/0", name, exp_q.size(), exp_grant_q.size());
    end
  endtask

  task automatic test_reset();
    out_request = 1'b1;
    do_reset();
    checks++;
    if ({grant, busy, out_valid, out_start, out_stop, out_data, out_error, in_cancel, in_request} !== '0) begin
      failures++;
      $display("FAIL reset_values: grant=%b busy=%b out_valid=%b out_data=%h in_cancel=%b in_request=%b",
               grant, busy, out_valid, out_data, in_cancel, in_request);
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (obs_request !== 2'b11) begin
      failures++; $display("FAIL request_rise: in_request=%b expected=11", obs_request);
    end
    out_request = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (obs_request !== 2'b00) begin
      failures++; $display("FAIL request_fall: in_request=%b expected=00", obs_request);
    end
    // Reset in the middle of a frame drops it without a STOP.
    do_reset();
    add_frame(0, 4, 0);
    exp_q.push_back(src0_q[0]);
    exp_grant_q.push_back(2'b01);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL reset_first_word: pending=%0d expected 0", exp_q.size());
    end
    do_reset();
    checks++;
    if ({grant, busy, out_valid, in_cancel} !== '0) begin
      failures++; $display("FAIL reset_midframe: grant=%b busy=%b out_valid=%b in_cancel=%b",
                           grant, busy, out_valid, in_cancel);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    add_frame(0, 4, 1);
    exp_grant_q.push_back(2'b01);
    step(1'b1, 1'b0);
    checks++;
    if (obs_grant !== 2'b00) begin
      failures++; $display("FAIL grant_latency_idle: grant=%b expected=00", obs_grant);
    end
    step(1'b1, 1'b0);
    checks++;
    if (obs_grant !== 2'b01) begin
      failures++; $display("FAIL grant_latency: grant=%b expected=01", obs_grant);
    end
    repeat (3) step(1'b1, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL frame_consecutive: pending=%0d expected 0", exp_q.size());
    end
    step(1'b1, 1'b0);
    checks++;
    if (obs_busy !== 1'b0) begin
      failures++; $display("FAIL busy_after_stop: busy=%b expected=0", obs_busy);
    end
    drain("single", 20);
  endtask

  task automatic test_round_robin();
    do_reset();
    add_frame(0, 3, 0);
    add_frame(0, 3, 0);
    add_frame(1, 3, 0);
    model_rr();
    drain("round_robin", 60);
  endtask

  task automatic test_stray();
    logic [WW-1:0] w;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      w = {2'b00, 1'b0, W'($urandom_range(0, 255))};
      src1_q.push_back(w);
    end
    add_frame(1, 3, 1);
    exp_grant_q.push_back(2'b10);
    step(1'b1, 1'b0);
    checks++;
    if (obs_ready !== 2'b10) begin
      failures++; $display("FAIL stray_flush: in_ready=%b expected=10", obs_ready);
    end
    drain("stray", 30);
  endtask

  task automatic test_ready_toggle();
    int n = 0;
    do_reset();
    add_frame(0, 4, 1);
    exp_grant_q.push_back(2'b01);
    while ((src0_q.size() > 0 || exp_q.size() > 0) && n < 40) begin
      step(1'(n % 2 == 0), 1'b0);
      n++;
    end
    drain("ready_toggle", 10);
  endtask

  task automatic test_cancel();
    do_reset();
    add_frame(0, 6, 0);
    exp_q.push_back(src0_q[0]);
    exp_q.push_back(src0_q[1]);
    add_frame(1, 3, 1);
    exp_grant_q.push_back(2'b01);
    exp_grant_q.push_back(2'b10);
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    checks++;
    if (obs_cancel !== 2'b01 || obs_busy !== 1'b0) begin
      failures++; $display("FAIL cancel_pulse: in_cancel=%b busy=%b expected 01/0", obs_cancel, obs_busy);
    end
    step(1'b1, 1'b0);
    checks++;
    if (obs_cancel !== 2'b00 || obs_grant !== 2'b10) begin
      failures++; $display("FAIL cancel_next: in_cancel=%b grant=%b expected 00/10", obs_cancel, obs_grant);
    end
    drain("cancel", 30);
  endtask

  task automatic test_stall();
    int cancels = 0, errors = 0, err_at = 0;
    do_reset();
    add_frame(0, 3, 0);
    exp_q.push_back(src0_q[0]);
`ifndef IMAGE_ARBITER_TIMEOUT_EN
    exp_q.push_back(src0_q[1]);
    exp_q.push_back(src0_q[2]);
`endif
    exp_grant_q.push_back(2'b01);
    stall_mask = 2'b01;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int c = 1; c <= 100; c++) begin
      step(1'b1, 1'b0);
      if (obs_cancel != '0) cancels++;
      if (obs_error && obs_busy) begin
        errors++;
        if (err_at == 0) err_at = c;
      end
    end
`ifdef IMAGE_ARBITER_TIMEOUT_EN
    checks++;
    if (cancels != 1 || errors != 1 || err_at != 11 || obs_busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout: cancels=%0d errors=%0d at=%0d busy=%b expected 1/1/11/0",
               cancels, errors, err_at, obs_busy);
    end
`else
    checks++;
    if (cancels != 0 || obs_busy !== 1'b1 || obs_grant !== 2'b01) begin
      failures++;
      $display("FAIL stall_hold: cancels=%0d busy=%b grant=%b expected 0/1/01", cancels, obs_busy, obs_grant);
    end
`endif
    stall_mask = '0;
    drain("stall", 20);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      do_reset();
      gaps = 1;
      rdy_rand = 1;
      for (int p = 0; p < N; p++) begin
        int nf;
        nf = $urandom_range(0, 4);
        for (int f = 0; f < nf; f++) add_frame(p, $urandom_range(1, 6), 0);
      end
      model_rr();
      drain("random", 600);
    end
  endtask

  initial begin
    reset = 1'b1;
    out_request = 1'b0;
    out_ready = 1'b0;
    out_cancel = 1'b0;
    in_valid = '0; in_start = '0; in_stop = '0; in_error = '0; in_data = '0;
    obs_busy = 1'b0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_stray();
    test_ready_toggle();
    test_cancel();
    test_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
